// File: rtl/stream_depatch.sv
// Block-to-raster re-serialiser: captures PATCH_HEIGHT x PATCH_WIDTH blocks into
// ping-pong band buffers and replays them as a raster stream PATCH_HEIGHT lines later.
module stream_depatch #(
    parameter int BIT_WIDTH    = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int IMAGE_WIDTH  = 8,
    parameter int FRAME_HEIGHT = 10,
    parameter int FRAME_WIDTH  = 12,
    parameter int PATCH_HEIGHT = 2,
    parameter int PATCH_WIDTH  = 2
) (
    input  logic                                        clock,
    input  logic                                        rst,
    input  logic                                        enable,
    input  logic [BIT_WIDTH*PATCH_WIDTH*PATCH_HEIGHT-1:0] in_patch,
    input  logic [$clog2(FRAME_HEIGHT)-1:0]             in_vcnt,
    input  logic [$clog2(FRAME_WIDTH)-1:0]              in_hcnt,
    output logic [BIT_WIDTH-1:0]                        out_pixel,
    output logic [$clog2(FRAME_HEIGHT)-1:0]             out_vcnt,
    output logic [$clog2(FRAME_WIDTH)-1:0]              out_hcnt
);

    localparam int VW    = $clog2(FRAME_HEIGHT);
    localparam int NBX   = IMAGE_WIDTH / PATCH_WIDTH;
    localparam int DEPTH = 2 * NBX;
    localparam int AW    = $clog2(DEPTH);
    localparam int NPIX  = PATCH_HEIGHT * PATCH_WIDTH;
    localparam int SW    = (NPIX > 1) ? $clog2(NPIX) : 1;

    int               vi, hi, ovi;
    logic             capture, wr_par, rd_par, rd_hit, hit_q;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [SW-1:0]    rd_sel, sel_q;
    logic [VW-1:0]    ov;
    logic [1:0]       band_valid;
    logic [BIT_WIDTH-1:0] rd_word [NPIX];

    // Write and read addresses both live in the [parity][block column] space.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        vi      = int'(in_vcnt);
        hi      = int'(in_hcnt);
        ovi     = (vi + FRAME_HEIGHT - PATCH_HEIGHT) % FRAME_HEIGHT;
        ov      = VW'(ovi);
        capture = !rst && enable
                  && (vi < IMAGE_HEIGHT) && (hi < IMAGE_WIDTH)
                  && (vi % PATCH_HEIGHT == PATCH_HEIGHT - 1)
                  && (hi % PATCH_WIDTH == PATCH_WIDTH - 1);
        wr_par  = 1'((vi / PATCH_HEIGHT) % 2);
        rd_par  = 1'((ovi / PATCH_HEIGHT) % 2);
        rd_hit  = (ovi < IMAGE_HEIGHT) && (hi < IMAGE_WIDTH) && band_valid[rd_par];
        wr_addr = '0;
        rd_addr = '0;
        if (capture)
            wr_addr = AW'(int'(wr_par) * NBX + hi / PATCH_WIDTH);
        if (hi < IMAGE_WIDTH)
            rd_addr = AW'(int'(rd_par) * NBX + hi / PATCH_WIDTH);
        rd_sel  = SW'((ovi % PATCH_HEIGHT) * PATCH_WIDTH + hi % PATCH_WIDTH);
    end

    // One bank per (row, column phase) so a whole block lands in a single cycle.
    for (genvar g = 0; g < NPIX; g++) begin : g_bank
        logic [BIT_WIDTH-1:0] mem [DEPTH];
        logic [BIT_WIDTH-1:0] rd_q;

        // NOTE: RAM and its read register carry no reset; band_valid/hit_q gate stale data instead.
        always_ff @(posedge clock) begin
            if (capture)
                mem[wr_addr] <= in_patch[g*BIT_WIDTH +: BIT_WIDTH];
            if (enable && !rst)
                rd_q <= mem[rd_addr];
        end

        assign rd_word[g] = rd_q;
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
        if (rst) begin
            out_vcnt   <= '0;
            out_hcnt   <= '0;
            hit_q      <= 1'b0;
            sel_q      <= '0;
            band_valid <= 2'b00;
        end else if (enable) begin
            out_vcnt <= ov;
            out_hcnt <= in_hcnt;
            hit_q    <= rd_hit;
            sel_q    <= rd_sel;
            if (capture)
                band_valid[wr_par] <= 1'b1;
        end
    end

    always_comb begin
        out_pixel = '0;
        if (hit_q)
            out_pixel = rd_word[sel_q];
    end

endmodule

// File: tb/tb_stream_depatch.sv
// Self-checking bench for stream_depatch: coordinate-level image model plus
// table-driven identity vectors and hand-written latency, stall and reset sequences.
module tb_stream_depatch;

    localparam int BW = 8, IH = 8, IW = 8, FH = 10, FW = 12, PH = 2, PW = 2;

    logic        clock = 1'b0;
    logic        rst, enable;
    logic [31:0] in_patch;
    logic [3:0]  in_vcnt, in_hcnt, out_vcnt, out_hcnt;
    logic [7:0]  out_pixel;

    always #5 clock = ~clock;

    stream_depatch #(
        .BIT_WIDTH(BW), .IMAGE_HEIGHT(IH), .IMAGE_WIDTH(IW),
        .FRAME_HEIGHT(FH), .FRAME_WIDTH(FW), .PATCH_HEIGHT(PH), .PATCH_WIDTH(PW)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .in_patch(in_patch),
        .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
        .out_pixel(out_pixel), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
    );

    typedef enum {M_ID, M_RAND, M_LAT} mode_t;
    typedef struct {int v; int h; int ev; int eh; int epix;} vec_t;

    int         n_cmp = 0, n_bad = 0;
    int         cur_v = 0, cur_h = 0;
    logic [7:0] img [IH][IW];
    bit         band_ok [2];
    int         m_pix = 0, m_v = 0, m_h = 0;
    vec_t       tbl [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at in(%0d,%0d): got 0x%0h, expected 0x%0h", name, cur_v, cur_h, act, exp);
        end
    endtask

    function automatic bit on_grid(input int v, input int h);
        return v < IH && h < IW && v % PH == PH - 1 && h % PW == PW - 1;
    endfunction

    task automatic build_patch(input mode_t m, output logic [31:0] p);
        logic [7:0] val;
        p = $urandom();
        if (on_grid(cur_v, cur_h)) begin
            for (int r = 0; r < PH; r++)
                for (int c = 0; c < PW; c++) begin
                    if (m == M_RAND)
                        val = 8'($urandom_range(255));
                    else
                        val = 8'(16 * (cur_v - PH + 1 + r) + (cur_h - PW + 1 + c));
                    if (m == M_LAT && cur_v == 1 && cur_h == 1 && r == 0 && c == 0)
                        val = 8'hA5;
                    p[(r*PW+c)*BW +: BW] = val;
                end
        end
    endtask

    // One clock: drive inputs, update the model, sample after the edge, compare.
    task automatic step(input mode_t m, input bit en, input bit do_rst);
        logic [31:0] p;
        int ov;
        build_patch(m, p);
        in_patch = p;
        in_vcnt  = 4'(cur_v);
        in_hcnt  = 4'(cur_h);
        enable   = en;
        rst      = do_rst;
        if (do_rst) begin
            m_pix = 0; m_v = 0; m_h = 0;
            band_ok[0] = 0; band_ok[1] = 0;
        end else if (en) begin
            ov    = (cur_v + FH - PH) % FH;
            m_v   = ov;
            m_h   = cur_h;
            m_pix = (ov < IH && cur_h < IW && band_ok[(ov / PH) % 2]) ? int'(img[ov][cur_h]) : 0;
            if (on_grid(cur_v, cur_h)) begin
                for (int r = 0; r < PH; r++)
                    for (int c = 0; c < PW; c++)
                        img[cur_v-PH+1+r][cur_h-PW+1+c] = p[(r*PW+c)*BW +: BW];
                band_ok[(cur_v / PH) % 2] = 1;
            end
        end
        @(posedge clock);
        #1;
        check("stream", int'({out_pixel, out_vcnt, out_hcnt}), (m_pix << 8) | (m_v << 4) | m_h);
        if (en) begin
            cur_h++;
            if (cur_h == FW) begin
                cur_h = 0;
                cur_v = (cur_v + 1) % FH;
            end
        end
    endtask

    task automatic run_until(input mode_t m, input int tv, input int th);
        for (int k = 0; k < 2 * FH * FW && !(cur_v == tv && cur_h == th); k++)
            step(m, 1'b1, 1'b0);
    endtask

    initial begin
        int n, saved;
        bit found;

        // Identity vectors: inputs at (v,h) show output (v-2 mod 10, h) one cycle later.
        tbl[0] = '{2, 0, 0, 0, 8'h00};
        tbl[1] = '{2, 5, 0, 5, 8'h05};
        tbl[2] = '{3, 7, 1, 7, 8'h17};
        tbl[3] = '{5, 3, 3, 3, 8'h33};
        tbl[4] = '{8, 2, 6, 2, 8'h62};
        tbl[5] = '{9, 7, 7, 7, 8'h77};
        tbl[6] = '{9, 8, 7, 8, 8'h00};
        tbl[7] = '{0, 4, 8, 4, 8'h00};
        tbl[8] = '{1, 11, 9, 11, 8'h00};
        tbl[9] = '{2, 1, 0, 1, 8'h01};

        rst = 1'b1; enable = 1'b0; in_patch = '0; in_vcnt = '0; in_hcnt = '0;
        step(M_ID, 1'b0, 1'b1);
        step(M_ID, 1'b0, 1'b1);
        check("reset_pixel", int'(out_pixel), 0);
        check("reset_vcnt", int'(out_vcnt), 0);
        check("reset_hcnt", int'(out_hcnt), 0);

        for (int k = 0; k < FH * FW; k++)
            step(M_ID, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            run_until(M_ID, tbl[i].v, tbl[i].h);
            step(M_ID, 1'b1, 1'b0);
            check("tbl_pixel", int'(out_pixel), tbl[i].epix);
            check("tbl_vcnt", int'(out_vcnt), tbl[i].ev);
            check("tbl_hcnt", int'(out_hcnt), tbl[i].eh);
        end

        // Latency of pixel (0,0) through the pipeline.
        run_until(M_ID, 0, 0);
        n = 0;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            step(M_LAT, 1'b1, 1'b0);
            n++;
            if (out_pixel == 8'hA5 && out_vcnt == 4'd0 && out_hcnt == 4'd0)
                found = 1;
        end
        check("latency_cycles", found ? n : -1, PH * FW + 1);

        // Random block contents, with a 5-cycle stall mid-line.
        run_until(M_RAND, 0, 0);
        run_until(M_RAND, 3, 3);
        saved = int'({out_pixel, out_vcnt, out_hcnt});
        for (int k = 0; k < 5; k++) begin
            step(M_RAND, 1'b0, 1'b0);
            check("stall_hold", int'({out_pixel, out_vcnt, out_hcnt}), saved);
        end
        run_until(M_RAND, 0, 0);
        for (int k = 0; k < FH * FW; k++)
            step(M_RAND, 1'b1, 1'b0);

        // Mid-frame reset: nothing nonzero until output line 4.
        run_until(M_ID, 4, 0);
        step(M_ID, 1'b1, 1'b1);
        check("midrst_out", int'({out_pixel, out_vcnt, out_hcnt}), 0);
        found = 0;
        for (int k = 0; k < 2 * FH * FW && !found; k++) begin
            step(M_ID, 1'b1, 1'b0);
            if (out_pixel != 8'h00)
                found = 1;
        end
        check("first_nonzero_line", found ? int'(out_vcnt) : -1, 4);
        check("first_nonzero_pixel", int'(out_pixel), 8'h40);
        run_until(M_ID, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
